// File: rtl/fpu_dp_pkg.sv
// Shared constants, state encoding and flag helpers
// for the sequential double-precision divider.
package fpu_dp_pkg;

  localparam int EXP_BIAS = 1023;
  localparam int EXP_W    = 11;
  localparam int MANT_W   = 52;
  localparam int ITER_CNT = 55;

  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  localparam int FLG_INV = 3;
  localparam int FLG_DZ  = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    ROUND,
    DONE
  } state_t;

  function automatic logic [3:0] mk_flags(
    input logic inv,
    input logic dz,
    input logic ovf,
    input logic unf
  );
    logic [3:0] f;
    f = '0;
    f[FLG_INV] = inv;
    f[FLG_DZ]  = dz;
    f[FLG_OVF] = ovf;
    f[FLG_UNF] = unf;
    return f;
  endfunction

endpackage

// File: rtl/fpu_dp_round_ne.sv
// Normalises a 55-bit restoring quotient, rounds it and
// packs the double result with overflow/underflow detection.
module fpu_dp_round_ne
  import fpu_dp_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic               [54:0] q,
  input  logic                      rem_nz,
  input  logic                      sign,
  input  logic signed        [12:0] exp_in,
  output logic               [63:0] result,
  output logic                      ovf,
  output logic                      unf
);

  logic [MANT_W-1:0] mant;
  logic [MANT_W:0]   sum;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic signed [12:0] e;

  always_comb begin
    if (q[54]) begin
      mant   = q[53:2];
      guard  = q[1];
      sticky = q[0] | rem_nz;
      e      = exp_in;
    end else begin
      mant   = q[52:1];
      guard  = q[0];
      sticky = rem_nz;
      e      = exp_in - 13'sd1;
    end
    inc = ROUND_EN && guard && (sticky || mant[0]);
    sum = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
    // mantissa carry leaves sum[51:0] at zero
    if (sum[MANT_W]) e = e + 13'sd1;
    ovf    = 1'b0;
    unf    = 1'b0;
    result = {sign, e[EXP_W-1:0], sum[MANT_W-1:0]};
    if (e >= 13'sd2047) begin
      ovf    = 1'b1;
      result = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (e <= 13'sd0) begin
      unf    = 1'b1;
      result = {sign, 63'b0};
    end
  end

endmodule

// File: rtl/fpu_dp_divider_seq.sv
// Multicycle double-precision divider: radix-2 restoring
// division, one quotient bit per clock, ready/valid on both sides.
module fpu_dp_divider_seq
  import fpu_dp_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  state_t state, state_nxt;

  logic [5:0]         cnt;
  logic [52:0]        mb;
  logic [53:0]        rem;
  logic [54:0]        q;
  logic signed [12:0] exp_q;
  logic               sign;
  logic [63:0]        res_q;
  logic [3:0]         flg_q;

  logic [EXP_W-1:0] ea, eb;
  logic a_nan, a_inf, a_zero;
  logic b_nan, b_inf, b_zero;
  logic sgn;
  logic special;
  logic [63:0] sp_res;
  logic [3:0]  sp_flg;

  assign ea  = a[WIDTH-2 -: EXP_W];
  assign eb  = b[WIDTH-2 -: EXP_W];
  assign sgn = a[WIDTH-1] ^ b[WIDTH-1];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (a[MANT_W-1:0] == '0);
  assign b_inf  = (&eb) && (b[MANT_W-1:0] == '0);
  assign a_nan  = (&ea) && (a[MANT_W-1:0] != '0);
  assign b_nan  = (&eb) && (b[MANT_W-1:0] != '0);

  // inf/0 is an exact infinity, so it is tested before x/0
  always_comb begin
    special = 1'b1;
    sp_res  = {sgn, 63'b0};
    sp_flg  = '0;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      sp_res = QNAN;
      sp_flg = mk_flags(1'b1, 1'b0, 1'b0, 1'b0);
    end else if (a_inf) begin
      sp_res = {sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (b_zero) begin
      sp_res = {sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      sp_flg = mk_flags(1'b0, 1'b1, 1'b0, 1'b0);
    end else if (a_zero | b_inf) begin
      sp_res = {sgn, 63'b0};
    end else begin
      special = 1'b0;
    end
  end

  logic        ge;
  logic [53:0] diff;

  assign ge   = (rem >= {1'b0, mb});
  assign diff = ge ? rem - {1'b0, mb} : rem;

  logic [63:0] rnd_res;
  logic        rnd_ovf;
  logic        rnd_unf;

  fpu_dp_round_ne #(
    .ROUND_EN (ROUND_EN)
  ) u_round (
    .q      (q),
    .rem_nz (rem != '0),
    .sign   (sign),
    .exp_in (exp_q),
    .result (rnd_res),
    .ovf    (rnd_ovf),
    .unf    (rnd_unf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (in_valid) state_nxt = special ? DONE : ITER;
      ITER:  if (cnt == 6'd0) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      mb    <= '0;
      rem   <= '0;
      q     <= '0;
      exp_q <= '0;
      sign  <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          sign  <= sgn;
          rem   <= {2'b01, a[MANT_W-1:0]};
          mb    <= {1'b1, b[MANT_W-1:0]};
          q     <= '0;
          cnt   <= 6'(ITER_CNT - 1);
          exp_q <= $signed(13'(ea) - 13'(eb) + 13'(EXP_BIAS));
          if (special) begin
            res_q <= sp_res;
            flg_q <= sp_flg;
          end
        end
        ITER: begin
          q   <= {q[53:0], ge};
          rem <= {diff[52:0], 1'b0};
          cnt <= (cnt == 6'd0) ? 6'd0 : cnt - 6'd1;
        end
        ROUND: begin
          res_q <= rnd_res;
          flg_q <= mk_flags(1'b0, 1'b0, rnd_ovf, rnd_unf);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q;
  assign flags     = flg_q;

endmodule
